// File: rtl/siso_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// siso_arbiter_ctrl
//
// Shares one serial shift-out lane between two parallel-word requesters.
// A round-robin arbiter grants one requester, captures its word, and the word
// is shifted out MSB-first, one bit per clock, with framing strobes for the
// downstream SISO shift-register chain. A stall input freezes the lane.
//
// Parameters:
//   WIDTH        bits per frame (2..16)
//   CW           bit-counter width, derived from WIDTH (do not override)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req0/data0   requester 0 request and word (word stable while req high)
//   req1/data1   requester 1 request and word
//   stall        freezes shifting and arbitration while high
//   gnt0/gnt1    one-cycle grant pulses (registered)
//   sout         serial bit, drives the chain's d input
//   sout_valid   sout carries a frame bit this cycle
//   frame_start  pulse with the MSB of a frame
//   frame_end    pulse with the LSB of a frame
//   busy         a frame is in progress
//   owner        requester index of the current frame (valid while busy)
// -----------------------------------------------------------------------------
module siso_arbiter_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             stall,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic             owner
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic             state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             prio;

    logic             grant;
    logic             win_idx;
    logic [WIDTH-1:0] win_data;

    // Arbitration: a lone requester always wins; on contention the
    // round-robin pointer decides.
    // NOTE: every always_comb output gets a value on every path (here by
    // unconditional assignment), so no latch can be inferred.
    always_comb begin
        grant    = (state == ST_IDLE) && !stall && (req0 || req1);
        win_idx  = (req0 && req1) ? prio : req1;
        win_data = win_idx ? data1 : data0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and covers every register; there is
        // no storage array here, so nothing is left uninitialised.
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            prio  <= 1'b0;
            owner <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
        end else begin
            // Grants are single-cycle pulses by default.
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        shreg <= win_data;
                        cnt   <= '0;
                        owner <= win_idx;
                        prio  <= ~win_idx;
                        gnt0  <= ~win_idx;
                        gnt1  <= win_idx;
                        state <= ST_SHIFT;
                    end
                end
                default: begin
                    if (!stall) begin
                        // The LSB is on sout this cycle; leave shreg alone
                        // since sout is forced to 0 in IDLE anyway.
                        if (cnt == LAST_BIT) begin
                            state <= ST_IDLE;
                        end else begin
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy        = (state == ST_SHIFT);
    assign sout        = busy ? shreg[WIDTH-1] : 1'b0;
    assign sout_valid  = busy && !stall;
    assign frame_start = sout_valid && (cnt == '0);
    assign frame_end   = sout_valid && (cnt == LAST_BIT);

endmodule

// File: tb/tb_siso_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_siso_arbiter_ctrl
//
// Self-checking bench for siso_arbiter_ctrl. Directed stimulus pushes the
// expected grant owners and serial bits of each frame into scoreboard queues;
// a negedge monitor pops and compares them as the DUT produces grants and
// valid bits. A second instance built with WIDTH=8 covers the wide frame.
// -----------------------------------------------------------------------------
module tb_siso_arbiter_ctrl;

    localparam int W = 4;

    typedef struct packed {
        logic b;
        logic fs;
        logic fe;
        logic own;
    } exp_bit_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, stall;
    logic [W-1:0] data0, data1;
    logic         gnt0, gnt1, sout, sout_valid, frame_start, frame_end, busy, owner;

    // WIDTH=8 instance signals
    logic         r8, z8;
    logic [7:0]   d8, zd8;
    logic         g8_0, g8_1, s8, v8, fs8, fe8, b8, o8;

    int n_checks = 0;
    int n_fail   = 0;

    exp_bit_t exp_bits[$];
    logic     exp_owner[$];
    logic     prev_gnt = 1'b0;

    always #5 clk = ~clk;

    siso_arbiter_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .stall(stall),
        .gnt0(gnt0), .gnt1(gnt1), .sout(sout), .sout_valid(sout_valid),
        .frame_start(frame_start), .frame_end(frame_end),
        .busy(busy), .owner(owner)
    );

    siso_arbiter_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .req0(r8), .data0(d8), .req1(z8), .data1(zd8),
        .stall(z8),
        .gnt0(g8_0), .gnt1(g8_1), .sout(s8), .sout_valid(v8),
        .frame_start(fs8), .frame_end(fe8),
        .busy(b8), .owner(o8)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic own, input logic [W-1:0] word);
        exp_owner.push_back(own);
        for (int i = 0; i < W; i++) begin
            exp_bits.push_back('{b: word[W-1-i], fs: (i == 0), fe: (i == W-1), own: own});
        end
    endtask

    // Returns the number of clock edges until a grant pulse is visible.
    task automatic wait_gnt(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(gnt0 || gnt1) && cycles < 30);
        if (!(gnt0 || gnt1)) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (busy && cycles < 40);
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        exp_bit_t e;
        logic     eo;
        if (gnt0 || gnt1) begin
            check("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
            check("gnt_back2back", {31'd0, prev_gnt}, 32'd0);
            if (exp_owner.size() == 0) begin
                check("gnt_unexpected", 32'd1, 32'd0);
            end else begin
                eo = exp_owner.pop_front();
                check("gnt_owner", {31'd0, gnt1}, {31'd0, eo});
            end
        end
        if (sout_valid) begin
            if (exp_bits.size() == 0) begin
                check("bit_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_bits.pop_front();
                check("sout_bit", {31'd0, sout}, {31'd0, e.b});
                check("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
                check("frame_end", {31'd0, frame_end}, {31'd0, e.fe});
                check("owner", {31'd0, owner}, {31'd0, e.own});
            end
        end else begin
            check("strobes_idle", {30'd0, frame_start, frame_end}, 32'd0);
        end
        if (!busy) check("sout_idle_zero", {31'd0, sout}, 32'd0);
        prev_gnt = gnt0 || gnt1;
    end

    initial begin
        int lat;
        int n;
        logic [7:0] word8;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; stall = 1'b0;
        data0 = '0; data1 = '0;
        r8 = 1'b0; z8 = 1'b0; d8 = '0; zd8 = '0;

        // ---- Reset state
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        check("rst_valid", {31'd0, sout_valid}, 32'd0);
        rst = 1'b0;

        // ---- Single frame
        data0 = 4'b1011; req0 = 1'b1;
        push_frame(1'b0, 4'b1011);
        wait_gnt(lat);
        req0 = 1'b0;
        check("single_latency", lat, 32'd1);
        check("single_gnt0", {31'd0, gnt0}, 32'd1);
        wait_idle(n);
        check("single_len", n, 32'd4);
        check("single_gap_valid", {31'd0, sout_valid}, 32'd0);

        // ---- Contention from reset
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 4'hA; data1 = 4'h5;
        tick(); tick();
        check("cont_rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        push_frame(1'b0, 4'hA); push_frame(1'b1, 4'h5);
        push_frame(1'b0, 4'hA); push_frame(1'b1, 4'h5);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(lat);
            if (k > 0) check("cont_period", lat, 32'd5);
            check("cont_order", {31'd0, gnt1}, k % 2);
            if (k == 2) req0 = 1'b0;
            if (k == 3) req1 = 1'b0;
        end
        wait_idle(n);

        // ---- Mid-frame stall
        tick();
        data1 = 4'b1100; req1 = 1'b1;
        push_frame(1'b1, 4'b1100);
        wait_gnt(lat);
        req1 = 1'b0;
        tick();          // 2nd bit on the lane
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            check("stall_valid", {31'd0, sout_valid}, 32'd0);
            check("stall_sout", {31'd0, sout}, 32'd0);
            check("stall_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        stall = 1'b0;
        wait_idle(n);
        check("stall_span", n + 5, 32'd7);

        // ---- Stall in IDLE
        stall = 1'b1; req1 = 1'b1; data1 = 4'h6;
        push_frame(1'b1, 4'h6);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_stall_gnt", {31'd0, gnt1}, 32'd0);
            check("idle_stall_busy", {31'd0, busy}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("idle_stall_release", {31'd0, gnt1}, 32'd1);
        req1 = 1'b0;
        wait_idle(n);

        // ---- Reset mid-frame (leaves prio at 1 before the reset)
        tick();
        data0 = 4'b1101; req0 = 1'b1;
        exp_owner.push_back(1'b0);
        exp_bits.push_back('{b: 1'b1, fs: 1'b1, fe: 1'b0, own: 1'b0});
        exp_bits.push_back('{b: 1'b1, fs: 1'b0, fe: 1'b0, own: 1'b0});
        wait_gnt(lat);
        req0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_sout", {31'd0, sout}, 32'd0);
        check("rstmid_valid", {31'd0, sout_valid}, 32'd0);
        check("rstmid_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        req0 = 1'b1; req1 = 1'b1; data0 = 4'h9; data1 = 4'h3;
        push_frame(1'b0, 4'h9);
        rst = 1'b0;
        wait_gnt(lat);
        req0 = 1'b0; req1 = 1'b0;
        check("rstmid_prio_latency", lat, 32'd1);
        check("rstmid_prio_gnt0", {31'd0, gnt0}, 32'd1);
        wait_idle(n);

        // ---- WIDTH=8 instance
        d8 = 8'h81; r8 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!g8_0 && n < 30);
        check("w8_gnt", {31'd0, g8_0}, 32'd1);
        word8 = '0;
        for (int i = 0; i < 8; i++) begin
            check("w8_valid", {31'd0, v8}, 32'd1);
            check("w8_end", {31'd0, fe8}, (i == 7) ? 32'd1 : 32'd0);
            word8 = {word8[6:0], s8};
            tick();
        end
        check("w8_word", {24'd0, word8}, 32'h81);
        check("w8_gap", {31'd0, v8}, 32'd0);
        n = 8;
        while (!g8_0 && n < 30) begin
            tick();
            n++;
        end
        r8 = 1'b0;
        check("w8_period", n, 32'd9);
        for (int i = 0; i < 10; i++) tick();

        check("sb_bits_left", exp_bits.size(), 32'd0);
        check("sb_gnts_left", exp_owner.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/siso_arbiter_ctrl.md
# siso_arbiter_ctrl

Shares one serial shift-out lane between two parallel-word requesters. A round-robin arbiter picks a requester and captures its word. The word is then shifted out MSB-first, one bit per clock, with framing strobes for the downstream SISO shift-register chain. The block sits in front of the 4-stage SISO chain and is its only driver of `d`. A `stall` input lets the consumer freeze the lane mid-frame.

## Interface
- `WIDTH`, default 4: bits per frame; legal range is 2 to 16.
- `CW`, default `$clog2(WIDTH)`: bit-counter width. Derived; do not override.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req0`, input, 1: requester 0 wants a frame. Held high until `gnt0`.
- `data0`, input, WIDTH: requester 0 word. Must be stable while `req0` is high.
- `req1`, input, 1: requester 1 wants a frame. Same rules as `req0`.
- `data1`, input, WIDTH: requester 1 word. Same rules as `data0`.
- `stall`, input, 1: freezes shifting and arbitration while high.
- `gnt0`, output, 1: one-cycle pulse; requester 0 word captured.
- `gnt1`, output, 1: one-cycle pulse; requester 1 word captured.
- `sout`, output, 1: serial bit. Connects to the chain's `d`.
- `sout_valid`, output, 1: `sout` carries a frame bit this cycle.
- `frame_start`, output, 1: pulse with the first (MSB) bit.
- `frame_end`, output, 1: pulse with the last (LSB) bit.
- `busy`, output, 1: high while state is SHIFT.
- `owner`, output, 1: requester index of the current frame. Meaningful only while `busy` is high.

## Operation
- **State.** FSM states are IDLE and SHIFT. Internal registers are `shreg[WIDTH-1:0]`, `cnt[CW-1:0]`, the round-robin pointer `prio` and `owner`.
- **IDLE, no grant.** If `stall` is high, or both requests are low, nothing changes.
- **IDLE, grant.** Otherwise pick a winner:
  - only one `req` high: that requester wins;
  - both high: requester `prio` wins.
- **Grant actions**, all on that edge:
  - `shreg` takes the winner's data;
  - `cnt` clears to 0;
  - `owner` takes the winner's index;
  - `prio` takes the loser's index (the inverse of the winner);
  - the winner's `gnt` is set for one cycle;
  - state moves to SHIFT.
- **SHIFT, stalled.** If `stall` is high, `shreg` and `cnt` hold and `sout_valid` is 0.
- **SHIFT, shifting.** Otherwise:
  - if `cnt` equals WIDTH-1, go to IDLE;
  - else shift `shreg` left one place, fill the LSB with 0, and increment `cnt`.
- **Combinational outputs:**
  - `sout` is `shreg[WIDTH-1]` in SHIFT and 0 in IDLE;
  - `sout_valid` is SHIFT and not `stall`;
  - `frame_start` is `sout_valid` and `cnt` equal to 0;
  - `frame_end` is `sout_valid` and `cnt` equal to WIDTH-1;
  - `busy` is state equal to SHIFT.
- **Registered outputs:** `gnt0`, `gnt1` and `owner`. `gnt` is never high in two consecutive cycles.
- **Held request.** A requester that keeps `req` high after its `gnt` is requesting another frame. With both requesters continuously requesting, grants alternate 0,1,0,1.
- **Reset values.** Applies at any time, including mid-frame. State goes to IDLE, `shreg` to 0, `cnt` to 0, `prio` to 0, `owner` to 0, `gnt0` and `gnt1` to 0. The aborted frame is dropped and no `gnt` is reissued for it.

## Timing
- **Grant latency.** A request sampled high in IDLE with `stall` low is granted at that edge (E0). `gnt` and the MSB on `sout` are both visible in the cycle after E0.
- **Frame length.** With no stall, bits appear in the cycles after E0 through E(WIDTH-1). State returns to IDLE at edge E(WIDTH).
- **Gap.** There is exactly one idle cycle between back-to-back frames, with `sout_valid` at 0. The frame period is WIDTH+1 cycles.
- **Stall.** Each stalled cycle in SHIFT adds one cycle to the frame. The bit on `sout` resumes unchanged after the stall.
- **Stall in IDLE.** Delays the grant and does not disturb `prio`.
- **Chain latency.** The chain output `q` lags `sout` by 4 cycles; that accounting belongs to the consumer.

## Test plan
- **Single frame.** `rst` for 2 cycles, then `req0`=1 with `data0`=4'b1011.
  - `gnt0` pulses in the cycle after the grant edge.
  - `sout` reads 1,0,1,1 on 4 consecutive valid cycles.
  - `frame_start` on the first bit, `frame_end` on the 4th; then one cycle with `busy`=0.
- **Contention.** `req0` and `req1` both held high from reset, with `data0`=4'hA and `data1`=4'h5.
  - Grant order is 0,1,0,1.
  - Serial stream is 1010 gap 0101 gap 1010 gap 0101; each frame is 5 cycles apart.
- **Mid-frame stall.** `data1`=4'b1100; assert `stall` for 3 cycles after the 2nd bit.
  - `sout_valid` is low for 3 cycles while `sout` holds 0.
  - The remaining bits are 0,0; the frame spans 7 cycles from `gnt1` to the cycle after `frame_end`.
- **Stall in IDLE.** `stall`=1 and `req1`=1 for 4 cycles: no `gnt1`, `busy`=0.
  - Drop `stall`: `gnt1` appears in the following cycle.
- **Reset mid-frame.** Assert `rst` after the 2nd bit of a `req0` frame.
  - The next cycle shows `busy`=0, `sout`=0, `sout_valid`=0, `gnt0`=`gnt1`=0.
  - After release, with both requests high, requester 0 wins because `prio` was reset to 0.
- **WIDTH=8 build.** Set `data0`=8'h81.
  - Stream reads 1,0,0,0,0,0,0,1; `frame_end` on the 8th bit; period is 9 cycles.
